// File: rtl/mean_pkg.sv
// rtl/mean_pkg.sv - shared widths and sample type for the window loader and mean_value averager.
package mean_pkg;
  localparam int DATA_W  = 16;
  localparam int WIN_LEN = 8;

  typedef logic [DATA_W-1:0] sample_t;
endpackage

// File: rtl/sample_window_loader_if.sv
// rtl/sample_window_loader_if.sv - sample stream in, parallel window out, both valid/ready.
interface sample_window_loader_if #(
  parameter int DATA_W = mean_pkg::DATA_W
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic              win_valid;
  logic              win_ready;

  modport master (
    output in_data, in_valid, win_ready,
    input  in_ready, x0, x1, x2, x3, x4, x5, x6, x7, win_valid
  );

  modport slave (
    input  in_data, in_valid, win_ready,
    output in_ready, x0, x1, x2, x3, x4, x5, x6, x7, win_valid
  );
endinterface

// File: rtl/window_shift_reg.sv
// rtl/window_shift_reg.sv - 8-deep sample shift register with saturating fill counter.
module window_shift_reg #(
  parameter int WIDTH = mean_pkg::DATA_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               shift_en,
  input  logic [WIDTH-1:0]                   shift_in,
  output logic [mean_pkg::WIN_LEN*WIDTH-1:0] sr_next,
  output logic [3:0]                         cnt
);
  localparam int WL = mean_pkg::WIN_LEN;

  // Entry 0 sits in the low word; a shift drops it and appends the new sample on top.
  logic [WL*WIDTH-1:0] sr;

  assign sr_next = (sr >> WIDTH) | {shift_in, {((WL-1)*WIDTH){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (shift_en) begin
      sr <= sr_next;
      if (cnt != 4'(WL)) cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/sample_window_loader.sv
// rtl/sample_window_loader.sv - collects serial samples into 8-word windows with hop control.
module sample_window_loader #(
  parameter int DATA_W = mean_pkg::DATA_W,
  parameter int HOP    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  sample_window_loader_if.slave        bus,
  output logic [15:0]                  win_count
);
  localparam int WL = mean_pkg::WIN_LEN;

  logic [WL*DATA_W-1:0] sr_next;
  logic [WL*DATA_W-1:0] win;
  logic [3:0]           cnt;
  logic [2:0]           hop;
  logic                 due_next;
  logic                 accept;
  logic                 load;
  logic                 win_valid;

  window_shift_reg #(.WIDTH(DATA_W)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .shift_en (accept),
    .shift_in (bus.in_data),
    .sr_next  (sr_next),
    .cnt      (cnt)
  );

  // Only the sample that would create the next window is held back by a pending window.
  assign due_next     = (cnt == 4'(WL-1)) || ((cnt == 4'(WL)) && (hop == 3'(HOP-1)));
  assign bus.in_ready = !flush && !(due_next && win_valid && !bus.win_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept && due_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hop <= '0;
    end else if (flush) begin
      hop <= '0;
    end else if (accept) begin
      if (due_next)             hop <= '0;
      else if (cnt == 4'(WL))   hop <= hop + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= '0;
      win_valid <= 1'b0;
      win_count <= '0;
    end else if (load) begin
      win       <= sr_next;
      win_valid <= 1'b1;
      win_count <= win_count + 16'd1;
    end else if (win_valid && bus.win_ready) begin
      win_valid <= 1'b0;
    end
  end

  assign bus.win_valid = win_valid;
  assign bus.x0 = win[0*DATA_W +: DATA_W];
  assign bus.x1 = win[1*DATA_W +: DATA_W];
  assign bus.x2 = win[2*DATA_W +: DATA_W];
  assign bus.x3 = win[3*DATA_W +: DATA_W];
  assign bus.x4 = win[4*DATA_W +: DATA_W];
  assign bus.x5 = win[5*DATA_W +: DATA_W];
  assign bus.x6 = win[6*DATA_W +: DATA_W];
  assign bus.x7 = win[7*DATA_W +: DATA_W];
endmodule
